// File: rtl/map_arb_pkg.sv
// Shared types for the map ROM arbiter: logic-port FSM states, pipe tag encoding
// and the default ROM read latency.
package map_arb_pkg;

  localparam int DEF_ROM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    INFLIGHT = 2'd2
  } lg_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_VID  = 2'b01,
    TAG_LG   = 2'b10
  } tag_t;

endpackage

// File: rtl/map_arb_tag_pipe.sv
// Fixed-depth shift register of read tags; the last stage marks which requester
// owns the rom_dout word presented in the current cycle.
module map_arb_tag_pipe
  import map_arb_pkg::*;
#(
  parameter int DEPTH = 1 + DEF_ROM_LATENCY
) (
  input  logic clk,
  input  logic clear,
  input  tag_t tag_in,
  output tag_t tag_out
);

  logic [1:0] stage_reg  [DEPTH];
  logic [1:0] stage_next [DEPTH];

  assign stage_next[0] = tag_in;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= TAG_NONE;
      end
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign tag_out = tag_t'(stage_reg[DEPTH-1]);

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares the single-port map ROM between the video pixel path (strict priority)
// and game-logic lookups. Optional starvation guard: MAP_ARB_STARVE_GUARD_EN.
module map_rom_arbiter
  import map_arb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY
`ifdef MAP_ARB_STARVE_GUARD_EN
  ,
  parameter int MAX_WAIT    = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              lg_req,
  input  logic [ADDR_W-1:0] lg_addr,
  output logic              lg_ack,
  output logic [DATA_W-1:0] lg_data,
  output logic              lg_valid,
  output logic              lg_busy,
`ifdef MAP_ARB_STARVE_GUARD_EN
  output logic              vid_drop,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  lg_state_t         state_reg, state_next;
  logic              starve;
  logic              lg_issue;
  logic              vid_win;
  tag_t              issue_tag, exit_tag;
  logic [DATA_W-1:0] vid_hold_reg, lg_hold_reg;

`ifdef MAP_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  logic [WAIT_W-1:0] wait_cnt_reg;

  // Counts cycles spent in PEND; restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (reset || state_reg != PEND) begin
      wait_cnt_reg <= '0;
    end else if (wait_cnt_reg != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign starve   = (state_reg == PEND) && (wait_cnt_reg == WAIT_W'(MAX_WAIT));
  assign vid_drop = lg_issue & vid_req;
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:     if (lg_req) state_next = lg_issue ? INFLIGHT : PEND;
      PEND: begin
        if (!lg_req) begin
          state_next = IDLE;
        end else if (lg_issue) begin
          state_next = INFLIGHT;
        end
      end
      INFLIGHT: if (exit_tag == TAG_LG) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    lg_issue = 1'b0;
    lg_busy  = 1'b0;
    unique case (state_reg)
      IDLE:     lg_issue = lg_req & ~vid_req;
      PEND: begin
        lg_issue = lg_req & (~vid_req | starve);
        lg_busy  = 1'b1;
      end
      INFLIGHT: lg_busy = 1'b1;
      default: begin
        lg_issue = 1'b0;
        lg_busy  = 1'b0;
      end
    endcase
  end

  assign lg_ack = lg_issue;

  // A logic issue while video is requesting only happens when the guard fires.
  assign vid_win = vid_req & ~lg_issue;

  always_comb begin
    issue_tag = TAG_NONE;
    if (vid_win) begin
      issue_tag = TAG_VID;
    end else if (lg_issue) begin
      issue_tag = TAG_LG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (vid_win) begin
      rom_addr <= vid_addr;
    end else if (lg_issue) begin
      rom_addr <= lg_addr;
    end
  end

  map_arb_tag_pipe #(
    .DEPTH (1 + ROM_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .clear   (reset),
    .tag_in  (issue_tag),
    .tag_out (exit_tag)
  );

  // The exit tag lines up with the rom_dout word; the hold registers keep it afterwards.
  assign vid_valid = (exit_tag == TAG_VID);
  assign lg_valid  = (exit_tag == TAG_LG);
  assign vid_data  = vid_valid ? rom_dout : vid_hold_reg;
  assign lg_data   = lg_valid  ? rom_dout : lg_hold_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_hold_reg <= '0;
      lg_hold_reg  <= '0;
    end else begin
      if (vid_valid) vid_hold_reg <= rom_dout;
      if (lg_valid)  lg_hold_reg  <= rom_dout;
    end
  end

endmodule
